timer_apb_sequencer: RTL and testbench

- APB master controller that programs and services the 8-bit APB timer without CPU involvement.
- On a start pulse it:
  - loads the timer data register and enables counting;
  - polls the status register for the overflow or underflow flag;
  - clears the flag and counts events, optionally reloading the period, until a programmed event count is reached or the run is aborted.
- It sits between system control logic and the timer's APB slave port, on the same pclk domain.

---
 rtl/timer_pkg.sv | 45 ++++
 rtl/apb_master_xfer.sv | 49 ++++
 rtl/timer_apb_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_timer_apb_sequencer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - register map, bit positions and sequencer states for the timer APB sequencer
package timer_pkg;

  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;

  localparam int TCR_LOAD   = 7;
  localparam int TCR_DOWN   = 5;
  localparam int TCR_EN     = 4;
  localparam int TCR_CKS_LO = 0;

  localparam int TSR_OVF = 0;
  localparam int TSR_UDF = 1;

  typedef enum logic [3:0] {
    S_IDLE,
    S_W_TDR,
    S_W_LOAD,
    S_W_RUN,
    S_POLL,
    S_GAP,
    S_CLR,
    S_STOP,
    S_ERR
  } seq_state_t;

  // States that own exactly one APB transfer
  function automatic logic is_xfer(input seq_state_t s);
    return (s inside {S_W_TDR, S_W_LOAD, S_W_RUN, S_POLL, S_CLR, S_STOP});
  endfunction

  // Assemble a TCR value from its fields
  function automatic logic [7:0] tcr_word(input logic load, input logic down,
                                          input logic en, input logic [1:0] cks);
    logic [7:0] w;
    w = '0;
    w[TCR_LOAD] = load;
    w[TCR_DOWN] = down;
    w[TCR_EN]   = en;
    w[TCR_CKS_LO +: 2] = cks;
    return w;
  endfunction

endpackage

// File: rtl/apb_master_xfer.sv
// rtl/apb_master_xfer.sv - single-transfer APB SETUP/ACCESS engine
module apb_master_xfer (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  input  logic       write,
  output logic       done,
  output logic [7:0] rdata,
  output logic       slverr,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr
);

  // A transfer completes in the ACCESS cycle where the slave is ready
  assign done   = psel & penable & pready;
  assign rdata  = prdata;
  assign slverr = pslverr;

  // A request launches SETUP (also on the completing edge, giving back-to-back transfers)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      psel    <= 1'b0;
      penable <= 1'b0;
      pwrite  <= 1'b0;
      paddr   <= 8'h00;
      pwdata  <= 8'h00;
    end else if (req) begin
      psel    <= 1'b1;
      penable <= 1'b0;
      pwrite  <= write;
      paddr   <= addr;
      pwdata  <= wdata;
    end else if (psel && !penable) begin
      penable <= 1'b1;
    end else if (done) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end
  end

endmodule

// File: rtl/timer_apb_sequencer.sv
// rtl/timer_apb_sequencer.sv - APB master that programs and services the 8-bit timer
module timer_apb_sequencer #(
  parameter int POLL_GAP = 8
) (
  input  logic       pclk,
  input  logic       preset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_period,
  input  logic       cfg_down,
  input  logic [1:0] cfg_cks,
  input  logic       cfg_reload,
  input  logic [7:0] cfg_events,
  output logic       psel,
  output logic       penable,
  output logic       pwrite,
  output logic [7:0] paddr,
  output logic [7:0] pwdata,
  input  logic [7:0] prdata,
  input  logic       pready,
  input  logic       pslverr,
  output logic       busy,
  output logic       tick,
  output logic       done,
  output logic       err,
  output logic [7:0] event_cnt
);
  import timer_pkg::*;

  seq_state_t state, next_state;

  logic [7:0] period_q, events_q, gap_cnt;
  logic [1:0] cks_q;
  logic       down_q, reload_q, abort_pend;

  logic       xreq, xwrite, xdone, xslverr;
  logic [7:0] xaddr, xwdata, xrdata;

  logic [7:0] cur_period, flag_mask;
  logic [1:0] cur_cks;
  logic       cur_down, accept, abort_req, flag, last_event, ok_done;

  // The first write is issued from IDLE before the config registers are loaded
  assign cur_period = (state == S_IDLE) ? cfg_period : period_q;
  assign cur_down   = (state == S_IDLE) ? cfg_down   : down_q;
  assign cur_cks    = (state == S_IDLE) ? cfg_cks    : cks_q;

  assign accept     = (state == S_IDLE) && start;
  assign abort_req  = abort_pend | abort;
  assign flag_mask  = down_q ? (8'h01 << TSR_UDF) : (8'h01 << TSR_OVF);
  assign flag       = |(xrdata & flag_mask);
  assign last_event = (events_q != 8'h00) && ((event_cnt + 8'd1) == events_q);
  assign ok_done    = xdone && !xslverr;

  apb_master_xfer u_xfer (
    .clk     (pclk),
    .rst     (preset),
    .req     (xreq),
    .addr    (xaddr),
    .wdata   (xwdata),
    .write   (xwrite),
    .done    (xdone),
    .rdata   (xrdata),
    .slverr  (xslverr),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  // Next state: transfer states advance only when their transfer completes
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (start) next_state = S_W_TDR;
      S_GAP: begin
        if (abort_req)                          next_state = S_STOP;
        else if (gap_cnt == 8'(POLL_GAP - 1))   next_state = S_POLL;
      end
      S_ERR: next_state = S_IDLE;
      default: begin
        if (xdone) begin
          if (xslverr)                               next_state = S_ERR;
          else if (abort_req && state != S_STOP)     next_state = S_STOP;
          else begin
            case (state)
              S_W_TDR:  next_state = S_W_LOAD;
              S_W_LOAD: next_state = S_W_RUN;
              S_W_RUN:  next_state = S_POLL;
              S_POLL:   next_state = flag ? S_CLR : ((POLL_GAP == 0) ? S_POLL : S_GAP);
              S_CLR:    next_state = last_event ? S_STOP : (reload_q ? S_W_TDR : S_POLL);
              default:  next_state = S_IDLE;
            endcase
          end
        end
      end
    endcase
  end

  // Issue the transfer belonging to the state being entered
  always_comb begin
    xreq   = is_xfer(next_state) && (xdone || !is_xfer(state));
    xaddr  = ADDR_TSR;
    xwdata = 8'h00;
    xwrite = 1'b1;
    case (next_state)
      S_W_TDR: begin
        xaddr  = ADDR_TDR;
        xwdata = cur_period;
      end
      S_W_LOAD: begin
        xaddr  = ADDR_TCR;
        xwdata = tcr_word(1'b1, cur_down, 1'b0, cur_cks);
      end
      S_W_RUN: begin
        xaddr  = ADDR_TCR;
        xwdata = tcr_word(1'b0, cur_down, 1'b1, cur_cks);
      end
      S_POLL:  xwrite = 1'b0;
      S_STOP:  xaddr  = ADDR_TCR;
      default: ;
    endcase
  end

  // State register
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Configuration latch, abort pending flag and poll gap counter
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      period_q   <= 8'h00;
      events_q   <= 8'h00;
      cks_q      <= 2'b00;
      down_q     <= 1'b0;
      reload_q   <= 1'b0;
      abort_pend <= 1'b0;
      gap_cnt    <= 8'h00;
    end else begin
      if (accept) begin
        period_q <= cfg_period;
        events_q <= cfg_events;
        cks_q    <= cfg_cks;
        down_q   <= cfg_down;
        reload_q <= cfg_reload;
      end
      if (next_state == S_STOP || next_state == S_IDLE)
        abort_pend <= 1'b0;
      else if (abort && !(state inside {S_IDLE, S_STOP, S_ERR}))
        abort_pend <= 1'b1;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : 8'h00;
    end
  end

  // Status outputs: busy follows the state, tick/done pulse after the completing transfer
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      busy      <= 1'b0;
      tick      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      event_cnt <= 8'h00;
    end else begin
      busy <= (next_state != S_IDLE);
      tick <= (state == S_CLR) && ok_done;
      done <= (state == S_STOP) && ok_done;
      if (accept) begin
        err       <= 1'b0;
        event_cnt <= 8'h00;
      end else begin
        if (xdone && xslverr)          err       <= 1'b1;
        if ((state == S_CLR) && ok_done) event_cnt <= event_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_timer_apb_sequencer.sv
// tb/tb_timer_apb_sequencer.sv - directed self-checking bench for timer_apb_sequencer
module tb_timer_apb_sequencer;

  logic       pclk = 1'b0, preset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [7:0] cfg_period = 8'h00, cfg_events = 8'h00;
  logic       cfg_down = 1'b0, cfg_reload = 1'b0;
  logic [1:0] cfg_cks = 2'b00;
  logic       psel, penable, pwrite, pready, pslverr, busy, tick, done, err;
  logic [7:0] paddr, pwdata, prdata, event_cnt;

  int vectors = 0, miscompares = 0;

  // slave model
  int         waits = 0, wcnt = 0, polls = 0;
  logic       err_en = 1'b0;
  logic [7:0] tdr_m = 8'h00, tcr_m = 8'h00, tsr_m = 8'h00;

  // bus monitor
  logic [20:0] xlog[$];
  logic [20:0] exp_q[$];
  int          ticks = 0, dones = 0, unstable = 0;
  logic [7:0]  done_cnt = 8'h00, s_addr = 8'h00, s_wdata = 8'h00;
  logic        s_write = 1'b0;
  logic [3:0]  acc_len = 4'd0;

  always #5 pclk = ~pclk;

  timer_apb_sequencer #(.POLL_GAP(8)) dut (
    .pclk(pclk), .preset(preset), .start(start), .abort(abort),
    .cfg_period(cfg_period), .cfg_down(cfg_down), .cfg_cks(cfg_cks),
    .cfg_reload(cfg_reload), .cfg_events(cfg_events),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .busy(busy), .tick(tick), .done(done), .err(err), .event_cnt(event_cnt)
  );

  assign pready  = psel && penable && (wcnt == waits);
  assign pslverr = pready && err_en && pwrite && (paddr == 8'h01) && (pwdata == 8'h80);
  assign prdata  = (paddr == 8'h02) ? tsr_m : ((paddr == 8'h01) ? tcr_m : tdr_m);

  // Timer slave: wait states, registers, flag raised after two clear polls
  always @(posedge pclk) begin
    if (psel && penable && !pready) wcnt <= wcnt + 1;
    else                            wcnt <= 0;
    if (start) begin
      tsr_m <= 8'h00;
      polls <= 0;
    end else if (pready && !pslverr) begin
      if (pwrite) begin
        case (paddr)
          8'h00: tdr_m <= pwdata;
          8'h01: tcr_m <= pwdata;
          8'h02: begin tsr_m <= pwdata; polls <= 0; end
          default: ;
        endcase
      end else if (paddr == 8'h02 && tsr_m == 8'h00) begin
        polls <= polls + 1;
        if (polls == 1) tsr_m <= tcr_m[5] ? 8'h02 : 8'h01;
      end
    end
  end

  // Transfer log, phase stability and pulse counters
  always @(posedge pclk) begin
    if (psel && !penable) begin
      s_addr  <= paddr;
      s_wdata <= pwdata;
      s_write <= pwrite;
      acc_len <= 4'd0;
    end else if (psel && penable) begin
      if (paddr !== s_addr || pwdata !== s_wdata || pwrite !== s_write) unstable <= unstable + 1;
      if (pready) xlog.push_back({acc_len + 4'd1, pwrite, paddr, (pwrite ? pwdata : prdata)});
      else        acc_len <= acc_len + 4'd1;
    end
    if (tick) ticks <= ticks + 1;
    if (done) begin
      dones    <= dones + 1;
      done_cnt <= event_cnt;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [20:0] ent(input int len, input logic w, input logic [7:0] a,
                                      input logic [7:0] d);
    return {len[3:0], w, a, d};
  endfunction

  task automatic build(input logic [7:0] period, input logic [7:0] load_v, input logic [7:0] run_v,
                       input logic [7:0] flag_v, input int n, input bit reload, input int len);
    exp_q.delete();
    for (int ev = 0; ev < n; ev++) begin
      if (ev == 0 || reload) begin
        exp_q.push_back(ent(len, 1'b1, 8'h00, period));
        exp_q.push_back(ent(len, 1'b1, 8'h01, load_v));
        exp_q.push_back(ent(len, 1'b1, 8'h01, run_v));
      end
      exp_q.push_back(ent(len, 1'b0, 8'h02, 8'h00));
      exp_q.push_back(ent(len, 1'b0, 8'h02, 8'h00));
      exp_q.push_back(ent(len, 1'b0, 8'h02, flag_v));
      exp_q.push_back(ent(len, 1'b1, 8'h02, 8'h00));
    end
    exp_q.push_back(ent(len, 1'b1, 8'h01, 8'h00));
  endtask

  task automatic cmp_log(input string tag, input int base);
    check({tag, "_len"}, xlog.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (base + i < xlog.size()) check($sformatf("%s_x%0d", tag, i), xlog[base + i], exp_q[i]);
  endtask

  task automatic go(input logic [7:0] period, input logic down, input logic [1:0] cks,
                    input logic reload, input logic [7:0] events);
    @(negedge pclk);
    cfg_period = period; cfg_down = down; cfg_cks = cks;
    cfg_reload = reload; cfg_events = events;
    start = 1'b1;
    @(negedge pclk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    for (int i = 0; i < budget && dones == d0; i++) @(negedge pclk);
    repeat (3) @(negedge pclk);
    check({tag, "_done"}, dones - d0, 1);
    check({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    int base, d0, t0, mark;
    logic any_psel;

    // reset state
    repeat (2) @(negedge pclk);
    check("reset", {psel, penable, pwrite, busy, tick, done, err, paddr, pwdata, event_cnt}, 0);
    preset = 1'b0;

    // up count, single event, zero wait states, with cycle-exact opening
    base = xlog.size(); d0 = dones; t0 = ticks;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    check("s1_cyc1", {psel, penable, pwrite, busy, paddr, pwdata}, 20'hB00F0);
    repeat (5) @(negedge pclk);
    check("s1_cyc6", {psel, penable, pready, pwrite, paddr, pwdata}, 20'hF0110);
    wait_done("s1", d0, 500);
    build(8'hF0, 8'h80, 8'h10, 8'h01, 1, 1'b0, 1);
    cmp_log("s1", base);
    check("s1_evcnt", done_cnt, 8'd1);
    check("s1_ticks", ticks - t0, 1);

    // down count with reload, three events
    base = xlog.size(); d0 = dones; t0 = ticks;
    go(8'h05, 1'b1, 2'b10, 1'b1, 8'd3);
    wait_done("s2", d0, 2000);
    build(8'h05, 8'hA2, 8'h32, 8'h02, 3, 1'b1, 1);
    cmp_log("s2", base);
    check("s2_evcnt", done_cnt, 8'd3);
    check("s2_ticks", ticks - t0, 3);

    // two wait states per transfer
    waits = 2;
    base = xlog.size(); d0 = dones; mark = unstable;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    wait_done("s3", d0, 1000);
    build(8'hF0, 8'h80, 8'h10, 8'h01, 1, 1'b0, 3);
    cmp_log("s3", base);
    check("s3_stable", unstable - mark, 0);
    check("s3_evcnt", done_cnt, 8'd1);
    waits = 0;

    // free-running, aborted in GAP after two events
    base = xlog.size(); d0 = dones; t0 = ticks;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd0);
    for (int i = 0; i < 1000 && ticks - t0 < 2; i++) @(negedge pclk);
    check("s4_two_ticks", ticks - t0, 2);
    for (int i = 0; i < 50 && psel; i++) @(negedge pclk);
    check("s4_in_gap", psel, 0);
    mark = xlog.size();
    abort = 1'b1;
    @(negedge pclk);
    abort = 1'b0;
    wait_done("s4", d0, 100);
    check("s4_one_more", xlog.size() - mark, 1);
    if (xlog.size() > mark) check("s4_stop_wr", xlog[mark], ent(1, 1'b1, 8'h01, 8'h00));
    check("s4_evcnt", done_cnt, 8'd2);

    // slave error on the load write
    err_en = 1'b1;
    base = xlog.size(); d0 = dones;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    for (int i = 0; i < 50 && !err; i++) @(negedge pclk);
    check("s5_err", err, 1);
    any_psel = 1'b0;
    repeat (6) begin
      @(negedge pclk);
      any_psel = any_psel | psel;
    end
    check("s5_no_psel", any_psel, 0);
    check("s5_busy", busy, 0);
    check("s5_no_done", dones - d0, 0);
    check("s5_xfers", xlog.size() - base, 2);
    if (xlog.size() > base + 1) check("s5_load_wr", xlog[base + 1], ent(1, 1'b1, 8'h01, 8'h80));
    err_en = 1'b0;
    d0 = dones;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    check("s5_err_clr", {err, busy}, 2'b01);
    wait_done("s5r", d0, 500);
    check("s5r_evcnt", done_cnt, 8'd1);

    // reset in the middle of a TSR access
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    for (int i = 0; i < 100 && !(psel && penable && paddr == 8'h02); i++) @(negedge pclk);
    check("s6_in_tsr", {psel, penable, paddr}, 10'h302);
    preset = 1'b1;
    #1;
    check("s6_reset", {psel, penable, pwrite, busy, tick, done, err, paddr, pwdata, event_cnt}, 0);
    @(negedge pclk);
    preset = 1'b0;
    base = xlog.size(); d0 = dones;
    go(8'hF0, 1'b0, 2'b00, 1'b0, 8'd1);
    wait_done("s6", d0, 500);
    build(8'hF0, 8'h80, 8'h10, 8'h01, 1, 1'b0, 1);
    cmp_log("s6", base);
    check("s6_evcnt", done_cnt, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
